// File: rtl/dice_result_mapper_pkg.sv
// Shared types and constants for the dice result mapper and its helpers.
package dice_result_mapper_pkg;

  // Number of distinct values a 7-bit SIPO sample can take.
  localparam int SAMPLE_RANGE = 128;
  // Smallest and largest die sizes that produce a meaningful roll.
  localparam int MIN_SIDES    = 2;
  localparam int MAX_SIDES    = 100;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    WAIT,
    MOD,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/dice_result_mapper_seq_mod.sv
// Iterative "acc mod divisor" unit: load a value, then subtract the divisor
// once per enabled cycle until the remainder drops below the divisor.
module seq_mod_subtractor #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_divisor,
  input  logic             i_run,
  output logic             o_done,
  output logic [ACC_W-1:0] o_rem
);

  logic [ACC_W-1:0] r_acc;

  assign o_done = (r_acc < i_divisor);
  assign o_rem  = r_acc;

  // Load on start, otherwise peel off one divisor per running cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_start) begin
      r_acc <= i_acc;
    end else if (i_run && !o_done) begin
      r_acc <= r_acc - i_divisor;
    end
  end

endmodule

// File: rtl/dice_result_mapper.sv
// Turns a SIPO random sample into an unbiased die face 1..sides. The largest
// multiple of sides that fits in the sample range is found first (SETUP),
// samples at or above it are rejected, and the accepted sample is reduced
// modulo sides by repeated subtraction (MOD).
module dice_result_mapper #(
  parameter int DATA_W    = 7,
  parameter int MAX_SIDES = dice_result_mapper_pkg::MAX_SIDES,
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_roll,
  input  logic [DATA_W-1:0] i_sides,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_sample_valid,
  output logic              o_sample_req,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_busy,
  output logic              o_error
);

  import dice_result_mapper_pkg::*;

  // One extra bit so the full sample range (128) is representable.
  localparam int ACC_W   = DATA_W + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  localparam logic [ACC_W-1:0]   L_RANGE     = ACC_W'(SAMPLE_RANGE);
  localparam logic [DATA_W-1:0]  L_MIN_SIDES = DATA_W'(MIN_SIDES);
  localparam logic [DATA_W-1:0]  L_MAX_SIDES = DATA_W'(MAX_SIDES);
  localparam logic [RETRY_W-1:0] L_RETRY_END = RETRY_W'(MAX_RETRY - 1);
  localparam logic [TMO_W-1:0]   L_TMO_END   = TMO_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_sides;
  logic [ACC_W-1:0]    r_limit;
  logic [RETRY_W-1:0]  r_retry;
  logic [TMO_W-1:0]    r_tmo;

  logic [DATA_W-1:0]   r_result;
  logic                r_sample_req;
  logic                r_result_valid;
  logic                r_busy;
  logic                r_error;

  logic                w_sides_ok;
  logic [ACC_W-1:0]    w_sample_ext;
  logic                w_accept;
  logic                w_retry_last;
  logic                w_tmo_last;
  logic                w_sub_start;
  logic [ACC_W-1:0]    w_sub_acc;
  logic                w_sub_run;
  logic                w_sub_done;
  logic [ACC_W-1:0]    w_sub_rem;

  assign w_sides_ok   = (i_sides >= L_MIN_SIDES) && (i_sides <= L_MAX_SIDES);
  assign w_sample_ext = {1'b0, i_sample};
  assign w_accept     = i_sample_valid && (w_sample_ext < r_limit);
  assign w_retry_last = (r_retry == L_RETRY_END);
  assign w_tmo_last   = (r_tmo == L_TMO_END);

  // The subtractor is shared: IDLE seeds it with the range for SETUP,
  // an accepted sample in WAIT seeds it for MOD.
  assign w_sub_start = ((r_state == IDLE) && i_roll && w_sides_ok) ||
                       ((r_state == WAIT) && w_accept);
  assign w_sub_acc   = (r_state == WAIT) ? w_sample_ext : L_RANGE;
  assign w_sub_run   = (r_state == SETUP) || (r_state == MOD);

  seq_mod_subtractor #(
    .ACC_W (ACC_W)
  ) u_mod (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_start   (w_sub_start),
    .i_acc     (w_sub_acc),
    .i_divisor ({1'b0, r_sides}),
    .i_run     (w_sub_run),
    .o_done    (w_sub_done),
    .o_rem     (w_sub_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; a valid sample takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_roll) w_next = w_sides_ok ? SETUP : ERR;
      SETUP:   if (w_sub_done) w_next = REQ;
      REQ:     w_next = WAIT;
      WAIT: begin
        if (i_sample_valid) begin
          if (w_accept)          w_next = MOD;
          else if (w_retry_last) w_next = ERR;
          else                   w_next = REQ;
        end else if (w_tmo_last) begin
          w_next = ERR;
        end
      end
      MOD:     if (w_sub_done) w_next = DONE;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Roll context: latched die size, rejection limit, retry and timeout counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sides <= '0;
      r_limit <= '0;
      r_retry <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_roll) begin
            r_sides <= i_sides;
            r_retry <= '0;
          end
        end
        SETUP:   if (w_sub_done) r_limit <= L_RANGE - w_sub_rem;
        REQ:     r_tmo <= '0;
        WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (i_sample_valid && !w_accept) r_retry <= r_retry + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs decoded from the state being entered, so each pulse
  // lines up exactly with its state and reset drops them all at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy         <= 1'b0;
      r_sample_req   <= 1'b0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_result       <= '0;
    end else begin
      r_busy         <= (w_next != IDLE);
      r_sample_req   <= (w_next == REQ);
      r_result_valid <= (w_next == DONE);
      r_error        <= (w_next == ERR);
      if ((r_state == MOD) && w_sub_done) r_result <= w_sub_rem[DATA_W-1:0] + 1'b1;
    end
  end

  assign o_busy         = r_busy;
  assign o_sample_req   = r_sample_req;
  assign o_result_valid = r_result_valid;
  assign o_error        = r_error;
  assign o_result       = r_result;

endmodule

// File: tb/tb_dice_result_mapper.sv
// Directed bench for dice_result_mapper with a SIPO responder and a
// face-value model driven by plain modulo arithmetic.
module tb_dice_result_mapper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_roll = 1'b0;
  logic [6:0] i_sides = '0;
  logic [6:0] i_sample = '0;
  logic       i_sample_valid = 1'b0;
  logic       o_sample_req;
  logic [6:0] o_result;
  logic       o_result_valid;
  logic       o_busy;
  logic       o_error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nreq = 0;
  int nerr = 0;
  int req_cyc = -1;
  int last_rv_cyc = -1;
  int exp_rv_cyc = -1;
  int exp_err_cyc = -1;
  int cur_sides = 0;
  int model_rej = 0;
  int last_v = 0;
  int n0 = 0;
  int e0 = 0;
  logic [6:0] exp_res = '0;
  logic [6:0] exp_res_next = '0;
  bit checking = 1'b0;
  bit ok;

  dice_result_mapper dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_roll         (i_roll),
    .i_sides        (i_sides),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_req   (o_sample_req),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every cycle: pulses only where the model predicts them, result held.
  always @(negedge clk) begin : compare
    bit rv_exp;
    bit er_exp;
    if (checking) begin
      rv_exp = (cyc == exp_rv_cyc);
      er_exp = (cyc == exp_err_cyc);
      if (rv_exp) exp_res = exp_res_next;
      check("result_valid", int'(o_result_valid), int'(rv_exp));
      check("error", int'(o_error), int'(er_exp));
      check("result", int'(o_result), int'(exp_res));
      if (o_result_valid) last_rv_cyc = cyc;
      if (o_error) nerr++;
      if (o_sample_req) begin
        nreq++;
        req_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit got);
    int start;
    start = nreq;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (nreq != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("req_timeout", 0, 1);
  endtask

  // Drive one sample-valid in the current cycle and predict its outcome.
  task automatic give(input int s);
    int lim;
    i_sample = 7'(s);
    i_sample_valid = 1'b1;
    last_v = cyc;
    lim = 128 - (128 % cur_sides);
    if (s < lim) begin
      exp_res_next = 7'(s % cur_sides + 1);
      exp_rv_cyc = last_v + s / cur_sides + 2;
    end else begin
      model_rej++;
      if (model_rej == 8) exp_err_cyc = last_v + 1;
    end
    tick();
    i_sample_valid = 1'b0;
    i_sample = '0;
  endtask

  task automatic serve(input int s, input int delay);
    bit got;
    wait_req(got);
    if (got) begin
      tick();
      repeat (delay) tick();
      give(s);
    end
  endtask

  task automatic roll(input int sides);
    cur_sides = sides;
    model_rej = 0;
    i_sides = 7'(sides);
    i_roll = 1'b1;
    tick();
    i_roll = 1'b0;
    i_sides = 7'd3;
    if (sides < 2 || sides > 100) exp_err_cyc = cyc;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_result", int'(o_result), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_req", int'(o_sample_req), 0);
    check("rst_error", int'(o_error), 0);
    reset_n = 1'b1;
    checking = 1'b1;
    tick();

    // sides=6, sample 37, i_roll held while busy
    n0 = nreq;
    cur_sides = 6;
    model_rej = 0;
    i_sides = 7'd6;
    i_roll = 1'b1;
    tick();
    i_sides = 7'd9;
    wait_req(ok);
    repeat (3) tick();
    i_roll = 1'b0;
    give(37);
    repeat (12) tick();
    check("t1_reqs", nreq - n0, 1);
    check("t1_latency", last_rv_cyc - last_v, 8);
    check("t1_result", int'(o_result), 2);
    check("t1_busy", int'(o_busy), 0);

    // sides=6, 127 rejected then 5 accepted
    n0 = nreq;
    e0 = nerr;
    roll(6);
    serve(127, 0);
    serve(5, 2);
    repeat (12) tick();
    check("t2_reqs", nreq - n0, 2);
    check("t2_result", int'(o_result), 6);
    check("t2_errors", nerr - e0, 0);

    // Illegal die sizes
    n0 = nreq;
    e0 = nerr;
    roll(1);
    repeat (3) tick();
    check("t3_busy_after_err", int'(o_busy), 0);
    roll(101);
    repeat (3) tick();
    check("t3_reqs", nreq - n0, 0);
    check("t3_errors", nerr - e0, 2);
    check("t3_result", int'(o_result), 6);

    // Retry overflow: sides=100, limit 100, samples of 120
    n0 = nreq;
    e0 = nerr;
    roll(100);
    for (int k = 0; k < 8; k++) serve(120, 1);
    repeat (3) tick();
    i_sample = 7'd120;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    repeat (3) tick();
    check("t4_reqs", nreq - n0, 8);
    check("t4_errors", nerr - e0, 1);
    check("t4_busy", int'(o_busy), 0);
    check("t4_result", int'(o_result), 6);

    // Timeout, then a normal roll
    e0 = nerr;
    roll(20);
    wait_req(ok);
    exp_err_cyc = req_cyc + 33;
    repeat (40) tick();
    check("t5_errors", nerr - e0, 1);
    check("t5_busy", int'(o_busy), 0);
    roll(20);
    serve(45, 0);
    repeat (10) tick();
    check("t5_result", int'(o_result), 6);

    // Reset during MOD
    roll(4);
    serve(99, 0);
    repeat (5) tick();
    check("t6_busy_in_mod", int'(o_busy), 1);
    reset_n = 1'b0;
    exp_rv_cyc = -1;
    exp_res = '0;
    #1;
    check("t6_rst_result", int'(o_result), 0);
    check("t6_rst_busy", int'(o_busy), 0);
    check("t6_rst_req", int'(o_sample_req), 0);
    check("t6_rst_valid", int'(o_result_valid), 0);
    check("t6_rst_error", int'(o_error), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("t6_result_after", int'(o_result), 0);
    check("t6_busy_after", int'(o_busy), 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_result_mapper.md
Name: dice_result_mapper

Overview:
Sits directly downstream of the SIPO random-bit deserializer. On a user roll request it commands the SIPO to capture a fresh 7-bit random sample, applies rejection sampling so every face is equally likely, and reduces the sample modulo the selected die size by sequential subtraction. It emits a face value 1..sides with a one-cycle valid pulse for the display/driver stage.

Parameters:
DATA_W, 7, width of the SIPO sample, the sides input and the result.
MAX_SIDES, 100, largest legal die size.
MAX_RETRY, 8, consecutive rejected samples tolerated before an error.
TIMEOUT, 32, cycles to wait for i_sample_valid after a request before an error.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
i_roll  in  1  roll request, sampled each cycle, acted on only in IDLE.
i_sides  in  DATA_W  die size, latched at roll acceptance.
i_sample  in  DATA_W  random sample from the SIPO (its o_data_out).
i_sample_valid  in  1  sample-ready pulse from the SIPO (its o_valid).
o_sample_req  out  1  one-cycle pulse that drives the SIPO i_start.
o_result  out  DATA_W  face value 1..sides, held until the next result.
o_result_valid  out  1  one-cycle pulse when o_result updates.
o_busy  out  1  high in every state except IDLE.
o_error  out  1  one-cycle pulse on an invalid die size, retry overflow or timeout.

Behaviour:
- Reset is async and active-low. It returns the FSM to IDLE and clears all outputs to 0, including o_result. All outputs are registered.
- IDLE: when i_roll=1, latch sides=i_sides.
  - If sides<2 or sides>MAX_SIDES, go to ERR.
  - Otherwise load acc=128 (8-bit), clear the retry count and go to SETUP.
- SETUP: one subtraction per cycle. While acc>=sides, acc-=sides. When acc<sides, set limit=128-acc and go to REQ. Example: sides=6 gives limit=126.
- REQ: o_sample_req=1 for exactly this cycle. Clear the timeout counter and go to WAIT.
- WAIT: the timeout counter increments every cycle.
  - On i_sample_valid with i_sample>=limit: reject. Increment the retry count; if it reaches MAX_RETRY go to ERR, otherwise go to REQ.
  - On i_sample_valid with i_sample<limit: set acc=i_sample and go to MOD.
  - If the counter reaches TIMEOUT with no valid, go to ERR.
- MOD: one subtraction per cycle while acc>=sides. When acc<sides, set o_result=acc+1 and go to DONE.
- DONE: o_result_valid=1 for one cycle, then go to IDLE.
- ERR: o_error=1 for one cycle, then go to IDLE. o_result keeps its previous value.
- Latency from the accepted sample to o_result_valid is floor(sample/sides)+2 cycles.
- i_roll outside IDLE is ignored; requests are not queued.
- i_sample_valid outside WAIT is ignored.
- A change on i_sides after the latch has no effect.
- If i_sample_valid arrives on the same cycle the timeout expires, the valid wins.
- Reset asserted mid-operation aborts the roll. No o_result_valid or o_error is produced, and o_sample_req drops immediately.
- Width rule: acc and limit are DATA_W+1 bits, so 128 is representable. o_result is always at most sides, which is at most 100 and fits in 7 bits.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, SETUP, REQ, WAIT, MOD, DONE, ERR}
  - the constants SAMPLE_RANGE=128, MIN_SIDES=2, MAX_SIDES
- One natural sub-module, seq_mod_subtractor. It is a start/done iterative "acc mod divisor" unit shared by SETUP and MOD.
- The FSM, retry counter and timeout counter stay in the top level.

Test Plan:
- sides=6, roll, SIPO returns sample 37 -> exactly one o_sample_req; o_result=2 with o_result_valid 8 cycles after the valid; o_busy low afterwards.
- sides=6, samples 127 then 5 -> 127 rejected (>=126) and a second o_sample_req is issued; final o_result=6; o_error never asserted.
- sides=1, then sides=101 -> o_error pulses once each, no o_sample_req, o_result unchanged.
- sides=100, nine consecutive samples of 120 -> after 8 rejects, o_error pulses once and FSM returns to IDLE with o_busy=0.
- sides=20, o_sample_req issued, no i_sample_valid for 32 cycles -> o_error pulse; a later roll with sample 45 -> o_result=6.
- sides=4, sample 99 accepted, reset_n asserted during MOD -> all outputs 0 immediately, no o_result_valid; i_roll held during a busy roll creates no extra request.
